// File: rtl/rx_deframer_pkg.sv
// Shared types and constants for the receive deframer.
package rx_deframer_pkg;
  typedef enum logic [1:0] {HUNT, PHR, PAYLOAD} stateT;
  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_OVF, ERR_TMO} errCodeT;

  localparam logic [7:0] SFD_DEFAULT = 8'hA7;
  localparam int         PHR_W       = 8;
endpackage

// File: rtl/rx_sync_detect.sv
// Sliding preamble+SFD window; match fires combinationally on the completing bit.
module rx_sync_detect
  import rx_deframer_pkg::*;
#(
  parameter int         PREAMBLE_MIN = 8,
  parameter logic [7:0] SYNC_WORD    = SFD_DEFAULT
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic bitIn,
  input  logic strobe,
  input  logic clear,
  output logic match
);
  localparam int W = PREAMBLE_MIN + 8;
  localparam logic [W-1:0] TARGET = {SYNC_WORD, {PREAMBLE_MIN{1'b0}}};

  // Only the W-1 most recent bits are stored; the incoming bit completes the window.
  logic [W-2:0] window;

  assign match = strobe && !clear && ({bitIn, window} == TARGET);

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)     window <= '1;
    else if (clear)  window <= '1;
    else if (strobe) window <= {bitIn, window[W-2:1]};
endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: hunts preamble+SFD, captures PHR length, emits payload nibbles.
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SFD_DEFAULT,
  parameter int         PREAMBLE_MIN = 8,
  parameter int         MAX_LEN      = 127,
  parameter int         TIMEOUT      = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flag,
  input  logic       i_data,
  input  logic       i_full,
  output logic       o_wr_en,
  output logic [3:0] o_data,
  output logic       o_frame_start,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic [6:0] o_len,
  output logic       o_busy
);
  localparam int TW = $clog2(TIMEOUT + 1);

  stateT         state, stateNxt;
  errCodeT       errCode, codeD;
  logic          match;
  logic [6:0]    phrSh;
  logic [2:0]    phrCnt;
  logic [2:0]    nibSh;
  logic [3:0]    nibble;
  logic [1:0]    nibBit;
  logic [7:0]    nibLeft;
  logic          ovf;
  logic [TW-1:0] idle;
  logic          inPhr, inPay, phrLast, nibLast, lenBad, tmo;
  logic          wrD, startD, doneD, errD, busyD;
  logic [3:0]    dataD;
  logic [6:0]    lenD;

  rx_sync_detect #(.PREAMBLE_MIN(PREAMBLE_MIN), .SYNC_WORD(SYNC_WORD)) uSync (
    .gclk  (i_clk),
    .grst_n(i_rst_n),
    .bitIn (i_data),
    .strobe(i_flag),
    .clear (state != HUNT),
    .match (match)
  );

  assign inPhr   = (state == PHR);
  assign inPay   = (state == PAYLOAD);
  assign phrLast = i_flag && (phrCnt == 3'(PHR_W - 1));
  assign nibLast = i_flag && (nibBit == 2'd3);
  assign nibble  = {i_data, nibSh};
  assign lenBad  = (phrSh == 7'd0) || (int'(phrSh) > MAX_LEN);
  // A strobe in the expiry cycle keeps the frame alive.
  assign tmo     = !i_flag && (idle == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= HUNT;
    else          state <= stateNxt;

  always_comb begin
    stateNxt = state;
    unique case (state)
      HUNT:    if (match) stateNxt = PHR;
      PHR:     if (tmo) stateNxt = HUNT;
               else if (phrLast) stateNxt = lenBad ? HUNT : PAYLOAD;
      PAYLOAD: if (tmo || (nibLast && nibLeft == 8'd1)) stateNxt = HUNT;
      default: stateNxt = HUNT;
    endcase
  end

  always_comb begin
    startD = 1'b0;
    wrD    = 1'b0;
    doneD  = 1'b0;
    errD   = 1'b0;
    dataD  = o_data;
    lenD   = o_len;
    codeD  = errCode;
    busyD  = (stateNxt != HUNT);
    unique case (state)
      HUNT:
        if (match) begin
          startD = 1'b1;
          codeD  = ERR_NONE;
        end
      PHR:
        if (tmo) begin
          errD  = 1'b1;
          codeD = ERR_TMO;
        end else if (phrLast) begin
          lenD = phrSh;
          if (lenBad) begin
            errD  = 1'b1;
            codeD = ERR_LEN;
          end
        end
      PAYLOAD:
        if (tmo) begin
          errD  = 1'b1;
          codeD = ERR_TMO;
        end else if (nibLast) begin
          dataD = nibble;
          wrD   = !i_full;
          if (nibLeft == 8'd1) begin
            if (ovf || i_full) begin
              errD  = 1'b1;
              codeD = ERR_OVF;
            end else begin
              doneD = 1'b1;
            end
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_wr_en       <= 1'b0;
      o_data        <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_len         <= '0;
      o_busy        <= 1'b0;
      errCode       <= ERR_NONE;
    end else begin
      o_wr_en       <= wrD;
      o_data        <= dataD;
      o_frame_start <= startD;
      o_frame_done  <= doneD;
      o_frame_err   <= errD;
      o_len         <= lenD;
      o_busy        <= busyD;
      errCode       <= codeD;
    end

  assign o_err_code = errCode;

  // PHR bit 7 is reserved, so only the first seven bits are shifted in.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      phrSh   <= '0;
      phrCnt  <= '0;
      nibSh   <= '0;
      nibBit  <= '0;
      nibLeft <= '0;
      ovf     <= 1'b0;
      idle    <= '0;
    end else begin
      if (inPhr && i_flag) begin
        if (!phrLast) phrSh <= {i_data, phrSh[6:1]};
        phrCnt <= phrCnt + 3'd1;
      end else if (!inPhr) begin
        phrCnt <= '0;
      end

      if (inPay && i_flag) begin
        nibSh  <= {i_data, nibSh[2:1]};
        nibBit <= nibBit + 2'd1;
      end else if (!inPay) begin
        nibBit <= '0;
      end

      if (inPhr && phrLast)      nibLeft <= {phrSh, 1'b0};
      else if (inPay && nibLast) nibLeft <= nibLeft - 8'd1;

      if (startD)                          ovf <= 1'b0;
      else if (inPay && nibLast && i_full) ovf <= 1'b1;

      if (!(inPhr || inPay) || i_flag) idle <= '0;
      else                             idle <= idle + TW'(1);
    end
endmodule

// File: tb/tb_rx_deframer.sv
// Frame-level scoreboard bench: stimulus pushes expected events, a negedge monitor checks them.
module tb_rx_deframer;
  localparam int PRE     = 8;
  localparam int TIMEOUT = 1024;
  localparam int EV_WR = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] data;
    logic [1:0] code;
    logic [6:0] len;
  } ev_t;

  logic       i_clk, i_rst_n, i_flag, i_data, i_full;
  logic       o_wr_en, o_frame_start, o_frame_done, o_frame_err, o_busy;
  logic [3:0] o_data;
  logic [1:0] o_err_code;
  logic [6:0] o_len;

  ev_t expq[$];
  ev_t drop;
  int  cyc = 0;
  int  lastCyc = 0;
  int  tests = 0;
  int  fails = 0;

  rx_deframer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flag(i_flag), .i_data(i_data), .i_full(i_full),
    .o_wr_en(o_wr_en), .o_data(o_data), .o_frame_start(o_frame_start),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
    .o_len(o_len), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "bench stalled");
  end

  task automatic cmp(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input int c, input logic [3:0] d,
                               input logic [1:0] code, input logic [6:0] len);
    ev_t e;
    e.kind = kind; e.cyc = c; e.data = d; e.code = code; e.len = len;
    expq.push_back(e);
  endfunction

  // Monitor: every observed pulse must match the oldest expected event.
  task automatic chk(input int kind);
    ev_t e;
    bit ok;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected event kind=%0d at cyc %0d, expected nothing", kind, cyc);
      return;
    end
    e = expq.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    case (kind)
      EV_WR:    ok = ok && (o_data == e.data);
      EV_START: ok = ok && (o_err_code == 2'd0) && o_busy;
      EV_DONE:  ok = ok && (o_len == e.len) && (o_err_code == 2'd0);
      default:  ok = ok && (o_len == e.len) && (o_err_code == e.code);
    endcase
    if (!ok) begin
      fails++;
      $display("FAIL event: got kind=%0d cyc=%0d data=%h code=%0d len=%0d busy=%0b, expected kind=%0d cyc=%0d data=%h code=%0d len=%0d",
               kind, cyc, o_data, o_err_code, o_len, o_busy, e.kind, e.cyc, e.data, e.code, e.len);
    end
  endtask

  always @(negedge i_clk) if (i_rst_n) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing event kind=%0d: not observed, expected at cyc %0d", expq[0].kind, expq[0].cyc);
      drop = expq.pop_front();
    end
    if (o_frame_done && o_frame_err) begin
      tests++;
      fails++;
      $display("FAIL exclusive pulses: done=1 err=1 at cyc %0d, expected at most one", cyc);
    end
    if (o_wr_en)       chk(EV_WR);
    if (o_frame_start) chk(EV_START);
    if (o_frame_done)  chk(EV_DONE);
    if (o_frame_err)   chk(EV_ERR);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int g(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  task automatic sendBit(input logic b, input logic f, input int gap);
    i_flag = 1'b0;
    repeat (gap) tick();
    i_flag = 1'b1;
    i_data = b;
    i_full = f;
    lastCyc = cyc;
    tick();
    i_flag = 1'b0;
  endtask

  task automatic pulseReset();
    i_flag = 1'b0;
    i_rst_n = 1'b0;
    #1;
    cmp("reset_outputs", {o_wr_en, o_data, o_frame_start, o_frame_done, o_frame_err,
                          o_err_code, o_len, o_busy}, 0);
    expq.delete();
    repeat (2) tick();
    i_rst_n = 1'b1;
  endtask

  task automatic endFrame();
    i_flag = 1'b0;
    repeat (2) tick();
    cmp("busy_after_frame", o_busy, 0);
  endtask

  task automatic sendFrame(input int nZeros, input logic [7:0] phr, input logic [7:0] b0,
                           input logic [7:0] b1, input int gap, input int fullNib,
                           input bit randFull, input int stallBit, input int stallGap,
                           input int rstBit);
    logic [7:0] pay[$];
    logic [7:0] sfd;
    logic [3:0] nib;
    int len, gg, bi;
    bit f, dropped;
    sfd = 8'hA7;
    repeat (2) sendBit(1'b1, 1'b0, g(gap));
    repeat (nZeros) sendBit(1'b0, 1'b0, g(gap));
    for (int i = 0; i < 8; i++) sendBit(sfd[i], 1'b0, g(gap));
    if (nZeros < PRE) begin
      sendBit(1'b1, 1'b0, g(gap));
      endFrame();
      return;
    end
    push(EV_START, lastCyc + 1, 4'h0, 2'd0, 7'd0);
    for (int i = 0; i < 8; i++) sendBit(phr[i], 1'b0, g(gap));
    len = int'(phr[6:0]);
    if (len == 0) begin
      push(EV_ERR, lastCyc + 1, 4'h0, 2'd1, 7'd0);
      endFrame();
      return;
    end
    for (int j = 0; j < len; j++) pay.push_back(j == 0 ? b0 : j == 1 ? b1 : 8'($urandom));
    dropped = 1'b0;
    for (int n = 0; n < 2 * len; n++) begin
      nib = n[0] ? pay[n/2][7:4] : pay[n/2][3:0];
      f = (n == fullNib) || (randFull && $urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        bi = n * 4 + k;
        gg = (bi == stallBit) ? stallGap : g(gap);
        if (bi == rstBit) begin
          pulseReset();
          endFrame();
          return;
        end
        if (gg >= TIMEOUT) begin
          push(EV_ERR, lastCyc + TIMEOUT + 1, 4'h0, 2'd3, 7'(len));
          i_flag = 1'b0;
          repeat (gg) tick();
          endFrame();
          return;
        end
        sendBit(nib[k], f, gg);
      end
      if (!f) push(EV_WR, lastCyc + 1, nib, 2'd0, 7'd0);
      else    dropped = 1'b1;
      if (n == 2 * len - 1) begin
        if (dropped) push(EV_ERR, lastCyc + 1, 4'h0, 2'd2, 7'(len));
        else         push(EV_DONE, lastCyc + 1, 4'h0, 2'd0, 7'(len));
      end
    end
    endFrame();
  endtask

  initial begin
    logic [7:0] sfd;
    i_rst_n = 1'b1;
    i_flag  = 1'b0;
    i_data  = 1'b0;
    i_full  = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 cmp("reset_state", {o_wr_en, o_data, o_frame_start, o_frame_done, o_frame_err,
                           o_err_code, o_len, o_busy}, 0);
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();

    // Basic frame, bit every 4 cycles
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 3, -1, 1'b0, -1, 0, -1);
    // Short and long preambles
    sendFrame(7, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, -1, 0, -1);
    sendFrame(12, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, -1, 0, -1);
    // Bad lengths, then a good frame
    sendFrame(8, 8'h00, 8'h3C, 8'h5A, 0, -1, 1'b0, -1, 0, -1);
    sendFrame(8, 8'h80, 8'h3C, 8'h5A, 0, -1, 1'b0, -1, 0, -1);
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 0, -1, 1'b0, -1, 0, -1);
    // FIFO full on the second nibble
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 3, 1, 1'b0, -1, 0, -1);
    // Timeout after 5 payload bits, then a strobe exactly at the limit
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, 5, TIMEOUT, -1);
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, 5, TIMEOUT - 1, -1);
    // Reset mid-payload, then partial preamble, then fresh frame
    sendFrame(8, 8'h02, 8'h00, 8'h00, 1, -1, 1'b0, -1, 0, 6);
    sendFrame(5, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, -1, 0, -1);
    sendFrame(8, 8'h02, 8'h3C, 8'h5A, 1, -1, 1'b0, -1, 0, -1);
    // Zeros seen in HUNT are forgotten across a reset
    sfd = 8'hA7;
    repeat (PRE) sendBit(1'b0, 1'b0, 1);
    pulseReset();
    for (int i = 0; i < 8; i++) sendBit(sfd[i], 1'b0, 1);
    sendBit(1'b1, 1'b0, 1);
    endFrame();

    for (int r = 0; r < 25; r++)
      sendFrame($urandom_range(5, 12), {1'($urandom), 7'($urandom_range(0, 5))},
                8'($urandom), 8'($urandom), -1, -1, ($urandom_range(0, 2) == 0),
                -1, 0, -1);

    repeat (5) tick();
    cmp("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
